cmap_lut: RTL

Parametrised, pipelined false-color mapper for the spectrogram display path. It replaces the fixed single-table pixel-to-RGB maps.
- Holds NMAPS run-time-loadable RGB tables.
- Streams pixels through a valid/ready pipeline.
- Switches the active map only on frame boundaries.
- Sits between the log-magnitude/scaling stage and the video/frame-buffer writer.

---
 rtl/cmap_lut.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cmap_lut.sv
// cmap_lut: pipelined false-colour mapper with NMAPS run-time tables, frame-boundary map switching.
// Optional run-time table write port enabled by defining CMAP_LOAD_EN.
module cmap_lut #(
  parameter int IW    = 8,
  parameter int OW    = 8,
  parameter int NMAPS = 4,
  parameter int MW    = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [MW-1:0]   i_sel,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [IW-1:0]   s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [OW-1:0]   m_r,
  output logic [OW-1:0]   m_g,
  output logic [OW-1:0]   m_b,
  output logic            m_last,
  input  logic            i_wr,
  input  logic [MW-1:0]   i_wr_map,
  input  logic [IW-1:0]   i_wr_addr,
  input  logic [3*OW-1:0] i_wr_data,
  output logic            o_wr_ack,
  output logic            o_busy
);

  localparam int AW    = MW + IW;
  localparam int DEPTH = NMAPS << IW;
  localparam int W     = 3 * OW;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [W-1:0]    r_mem [DEPTH];
  logic [W-1:0]    r_rd;
  logic            r_v1, r_l1;
  logic            r_sof;
  logic [MW-1:0]   r_active;

  logic            w_cnt_last, w_init_we, w_run, w_ce, w_acc, w_sel_ok;
  logic [MW-1:0]   w_sel, w_map;
  logic [AW-1:0]   w_raddr;

  // Grey ramp: index left-justified and its bits repeated down to OW bits.
  function automatic logic [OW-1:0] ramp(input logic [IW-1:0] idx);
    logic [OW-1:0] v;
    v = '0;
    for (int j = 0; j < OW; j++) v[OW-1-j] = idx[IW-1-(j % IW)];
    return v;
  endfunction

  assign w_cnt_last = (r_cnt == AW'(DEPTH - 1));
  assign w_init_we  = (r_state == ST_INIT) && i_reset_n;
  assign w_run      = (r_state == ST_RUN);
  assign o_busy     = (r_state == ST_INIT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (w_cnt_last) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign w_ce    = !m_valid || m_ready;
  assign s_ready = w_ce && w_run;
  assign w_acc   = s_valid && s_ready;

  // Out-of-range selects fall back to map 0; the map is latched only at frame start.
  assign w_sel_ok = ({1'b0, i_sel} < (MW+1)'(NMAPS));
  assign w_sel    = w_sel_ok ? i_sel : '0;
  assign w_map    = r_sof ? w_sel : r_active;
  assign w_raddr  = {w_map, s_data};

`ifdef CMAP_LOAD_EN
  logic w_wr;
  logic r_wr_ack;
  assign w_wr     = i_wr && w_run && i_reset_n;
  assign o_wr_ack = r_wr_ack;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_wr_ack <= 1'b0;
    else            r_wr_ack <= w_wr;
  end
`else
  logic w_unused_wr;
  assign w_unused_wr = ^{i_wr, i_wr_map, i_wr_addr, i_wr_data};
  assign o_wr_ack    = 1'b0;
`endif

  // Table storage: non-blocking write and read on the same edge gives read-first.
  always_ff @(posedge i_clk) begin
    if (w_init_we) r_mem[r_cnt] <= {3{ramp(r_cnt[IW-1:0])}};
`ifdef CMAP_LOAD_EN
    else if (w_wr) r_mem[{i_wr_map, i_wr_addr}] <= i_wr_data;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (w_ce) r_rd <= r_mem[w_raddr];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_v1     <= 1'b0;
      r_l1     <= 1'b0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_r      <= '0;
      m_g      <= '0;
      m_b      <= '0;
      r_sof    <= 1'b1;
      r_active <= '0;
    end else begin
      if (w_ce) begin
        r_v1    <= w_acc;
        r_l1    <= w_acc && s_last;
        m_valid <= r_v1;
        m_last  <= r_l1;
        m_r     <= r_rd[3*OW-1:2*OW];
        m_g     <= r_rd[2*OW-1:OW];
        m_b     <= r_rd[OW-1:0];
      end
      if (w_acc) begin
        r_sof <= s_last;
        if (r_sof) r_active <= w_sel;
      end
    end
  end

endmodule
